// File: rtl/i2c_target_regs.sv
// I2C target responder: decodes address/sub-address/data frames onto a local register port.
// Optional macro I2C_TARGET_AUTOINC_EN: REG_ADDR advances after each written or ACKed read byte.
module i2c_target_regs #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  output logic       REG_RE,
  input  logic [7:0] REG_RDATA,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_SUB   = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  logic [3:0] cnt_q, cnt_d;
  logic       ack_q, ack_d;
  logic       mack_q, mack_d;
  logic [7:0] shreg_q, shreg_d;
  logic       sda_drv_low_q, sda_drv_low_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_re_q, reg_re_d;
  logic       busy_q, busy_d;
  logic       addr_match;

  function automatic logic [7:0] next_addr(input logic [7:0] a);
`ifdef I2C_TARGET_AUTOINC_EN
    return a + 8'd1;
`else
    return a;
`endif
  endfunction

  // Input conditioning: synchroniser chain plus one history flop for edge/condition detection
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], I2C_SCLK};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], I2C_SDAT};
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_hist_q;
  assign scl_fall   = ~scl_s & scl_hist_q;
  assign start_det  = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det   = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
  assign addr_match = (shreg_q[7:1] == SLAVE_ADDR);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      scl_sync_q    <= '1;
      sda_sync_q    <= '1;
      scl_hist_q    <= 1'b1;
      sda_hist_q    <= 1'b1;
      cnt_q         <= 4'd0;
      ack_q         <= 1'b0;
      mack_q        <= 1'b0;
      sda_drv_low_q <= 1'b0;
      reg_addr_q    <= 8'd0;
      reg_wdata_q   <= 8'd0;
      reg_we_q      <= 1'b0;
      reg_re_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      scl_sync_q    <= scl_sync_d;
      sda_sync_q    <= sda_sync_d;
      scl_hist_q    <= scl_s;
      sda_hist_q    <= sda_s;
      cnt_q         <= cnt_d;
      ack_q         <= ack_d;
      mack_q        <= mack_d;
      sda_drv_low_q <= sda_drv_low_d;
      reg_addr_q    <= reg_addr_d;
      reg_wdata_q   <= reg_wdata_d;
      reg_we_q      <= reg_we_d;
      reg_re_q      <= reg_re_d;
      busy_q        <= busy_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    shreg_q <= shreg_d;
  end

  // Next-state logic; bus conditions override any byte in progress
  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_ADDR;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_fall && !ack_q && cnt_q == 4'd8 && !addr_match) state_d = ST_IDLE;
          else if (scl_fall && ack_q) state_d = shreg_q[0] ? ST_RDATA : ST_SUB;
        end
        ST_SUB: begin
          if (scl_fall && ack_q) state_d = ST_WDATA;
        end
        ST_RDATA: begin
          if (scl_rise && ack_q && sda_s) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Datapath and strobes
  always_comb begin
    cnt_d         = cnt_q;
    ack_d         = ack_q;
    mack_d        = mack_q;
    shreg_d       = shreg_q;
    sda_drv_low_d = sda_drv_low_q;
    reg_addr_d    = reg_addr_q;
    reg_wdata_d   = reg_wdata_q;
    reg_we_d      = 1'b0;
    reg_re_d      = 1'b0;
    busy_d        = busy_q;
    if (stop_det) begin
      cnt_d         = 4'd0;
      ack_d         = 1'b0;
      mack_d        = 1'b0;
      sda_drv_low_d = 1'b0;
      busy_d        = 1'b0;
    end else if (start_det) begin
      cnt_d         = 4'd0;
      ack_d         = 1'b0;
      mack_d        = 1'b0;
      sda_drv_low_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_SUB, ST_WDATA: begin
          if (!ack_q) begin
            if (scl_rise && cnt_q < 4'd8) begin
              shreg_d = {shreg_q[6:0], sda_s};
              cnt_d   = cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              cnt_d = 4'd0;
              if (state_q != ST_ADDR || addr_match) begin
                ack_d         = 1'b1;
                sda_drv_low_d = 1'b1;
              end
              if (state_q == ST_ADDR) busy_d = addr_match;
              if (state_q == ST_SUB) reg_addr_d = shreg_q;
              if (state_q == ST_WDATA) begin
                reg_wdata_d = shreg_q;
                reg_we_d    = 1'b1;
              end
            end
          end else if (scl_fall) begin
            ack_d         = 1'b0;
            sda_drv_low_d = 1'b0;
            if (state_q == ST_ADDR && shreg_q[0]) reg_re_d = 1'b1;
            if (state_q == ST_WDATA) reg_addr_d = next_addr(reg_addr_q);
          end
        end
        ST_RDATA: begin
          // The strobe cycle gives the register bank one CLOCK to present REG_RDATA
          if (reg_re_q) begin
            shreg_d       = REG_RDATA;
            sda_drv_low_d = ~REG_RDATA[7];
            cnt_d         = 4'd0;
          end else if (!ack_q) begin
            if (scl_fall) begin
              if (cnt_q == 4'd7) begin
                cnt_d         = 4'd0;
                ack_d         = 1'b1;
                sda_drv_low_d = 1'b0;
              end else begin
                cnt_d         = cnt_q + 4'd1;
                shreg_d       = {shreg_q[6:0], 1'b0};
                sda_drv_low_d = ~shreg_q[6];
              end
            end
          end else if (scl_rise) begin
            if (sda_s) begin
              ack_d         = 1'b0;
              busy_d        = 1'b0;
              sda_drv_low_d = 1'b0;
            end else begin
              mack_d = 1'b1;
            end
          end else if (scl_fall && mack_q) begin
            ack_d      = 1'b0;
            mack_d     = 1'b0;
            reg_addr_d = next_addr(reg_addr_q);
            reg_re_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // RESET gates the driver directly so SDA lets go in the cycle reset is applied
  assign I2C_SDAT  = (sda_drv_low_q && !RESET) ? 1'b0 : 1'bz;
  assign REG_ADDR  = reg_addr_q;
  assign REG_WDATA = reg_wdata_q;
  assign REG_WE    = reg_we_q;
  assign REG_RE    = reg_re_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C controller, register-bank model and transaction-level reference.
module tb_i2c_target_regs;
  localparam int Q = 5;
`ifdef I2C_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       tb_low = 1'b0;
  wire        sda;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;
  logic [7:0] mem [256];
  int         checks = 0;
  int         errors = 0;
  int         viol = 0;
  logic [15:0] wlog[$];
  logic [15:0] wexp[$];
  logic [7:0] m_addr;

  pullup (sda);
  assign sda = tb_low ? 1'b0 : 1'bz;
  assign reg_rdata = mem[reg_addr];
  always #5 clk = ~clk;

  i2c_target_regs dut (
    .CLOCK(clk), .RESET(rst), .I2C_SCLK(scl), .I2C_SDAT(sda),
    .REG_ADDR(reg_addr), .REG_WDATA(reg_wdata), .REG_WE(reg_we),
    .REG_RE(reg_re), .REG_RDATA(reg_rdata), .BUSY(busy)
  );

  always @(negedge clk) begin
    if (!rst && reg_we) wlog.push_back({reg_addr, reg_wdata});
    if ((reg_we && reg_re) || ((reg_we || reg_re) && !busy)) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic start_c;
    if (scl == 1'b0) begin
      wclk(Q); tb_low = 1'b0; wclk(Q); scl = 1'b1;
    end
    wclk(Q); tb_low = 1'b1; wclk(Q); scl = 1'b0;
  endtask

  task automatic stop_c;
    wclk(Q); tb_low = 1'b1; wclk(Q); scl = 1'b1; wclk(Q); tb_low = 1'b0; wclk(2*Q);
  endtask

  task automatic send_bit(input bit b);
    wclk(Q); tb_low = ~b; wclk(Q); scl = 1'b1; wclk(2*Q); scl = 1'b0;
  endtask

  task automatic get_bit(output bit b);
    wclk(Q); tb_low = 1'b0; wclk(Q); scl = 1'b1; wclk(2);
    @(negedge clk); b = sda;
    wclk(2*Q-3); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] v, output bit ack);
    bit b;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] v, input bit nack);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_nwr"}, wlog.size(), wexp.size());
    for (int i = 0; i < wexp.size() && i < wlog.size(); i++) chk({tag, "_wr"}, wlog[i], wexp[i]);
    wlog.delete();
    wexp.delete();
  endtask

  // Reference: a write frame to a matching address sets the pointer then stores each byte there
  task automatic do_write(input string tag, input logic [7:0] a, input logic [7:0] sub,
                          input int n, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    bit ack;
    bit match;
    logic [7:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    match = (a[7:1] == 7'h1A) && !a[0];
    start_c;
    write_byte(a, ack);
    chk({tag, "_aack"}, ack, match);
    chk({tag, "_busy"}, busy, match);
    write_byte(sub, ack);
    chk({tag, "_sack"}, ack, match);
    if (match) m_addr = sub;
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], ack);
      chk({tag, "_dack"}, ack, match);
      if (match) begin
        wexp.push_back({m_addr, d[i]});
        if (AUTOINC) m_addr = m_addr + 8'd1;
      end
    end
    chk({tag, "_busy_pre"}, busy, match);
    stop_c;
    chk({tag, "_busy_stop"}, busy, 1'b0);
    cmp_log(tag);
  endtask

  task automatic do_read(input string tag, input logic [7:0] sub, input int n);
    bit ack;
    logic [7:0] v;
    start_c;
    write_byte(8'h34, ack);
    chk({tag, "_aack"}, ack, 1'b1);
    write_byte(sub, ack);
    chk({tag, "_sack"}, ack, 1'b1);
    m_addr = sub;
    start_c;
    write_byte(8'h35, ack);
    chk({tag, "_raack"}, ack, 1'b1);
    for (int i = 0; i < n; i++) begin
      read_byte(v, i == n - 1);
      chk({tag, "_rdata"}, v, mem[m_addr]);
      if (i != n - 1 && AUTOINC) m_addr = m_addr + 8'd1;
    end
    chk({tag, "_busy_nack"}, busy, 1'b0);
    stop_c;
    chk({tag, "_busy_stop"}, busy, 1'b0);
    chk({tag, "_sda_rel"}, sda, 1'b1);
    cmp_log(tag);
  endtask

  initial begin
    bit ack;
    bit b;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    m_addr = 8'd0;

    wclk(5);
    @(negedge clk);
    chk("rst_addr", reg_addr, 8'h00);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_we_re", {reg_we, reg_re}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sda", sda, 1'b1);
    @(posedge clk); rst = 1'b0;
    wclk(5);

    do_write("wr_basic", 8'h34, 8'h0C, 1, 8'h5A, 8'h00, 8'h00);
    do_write("wr_badaddr", 8'h36, 8'h0C, 1, 8'h5A, 8'h00, 8'h00);
    mem[8'h05] = 8'hA5;
    do_read("rd_basic", 8'h05, 1);
    do_write("wr_wrap", 8'h34, 8'hFF, 2, 8'h11, 8'h22, 8'h00);

    // Reset during the 4th bit of a read byte whose bits are all zero
    mem[8'h20] = 8'h00;
    start_c;
    write_byte(8'h34, ack);
    write_byte(8'h20, ack);
    start_c;
    write_byte(8'h35, ack);
    chk("rst_mid_raack", ack, 1'b1);
    for (int i = 0; i < 3; i++) get_bit(b);
    chk("rst_mid_bit", b, 1'b0);
    wclk(2*Q); scl = 1'b1; wclk(3);
    @(negedge clk);
    chk("rst_mid_drv", sda, 1'b0);
    @(posedge clk); rst = 1'b1;
    #1;
    chk("rst_mid_release", sda, 1'b1);
    wclk(3);
    @(negedge clk);
    chk("rst_mid_addr", reg_addr, 8'h00);
    chk("rst_mid_wdata", reg_wdata, 8'h00);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_we_re", {reg_we, reg_re}, 2'b00);
    @(posedge clk); rst = 1'b0;
    m_addr = 8'd0;
    wlog.delete();
    wexp.delete();
    wclk(5);
    do_write("post_rst", 8'h34, 8'h01, 1, 8'h77, 8'h00, 8'h00);

    // STOP after 5 bits of a data byte discards it
    start_c;
    write_byte(8'h34, ack);
    write_byte(8'h10, ack);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    stop_c;
    chk("partial_busy", busy, 1'b0);
    cmp_log("partial");
    do_write("after_partial", 8'h34, 8'h11, 1, 8'h3C, 8'h00, 8'h00);

    for (int r = 0; r < 8; r++) begin
      case ($urandom_range(0, 2))
        0: do_write("rnd_wr", 8'h34, 8'($urandom), int'($urandom_range(1, 3)),
                    8'($urandom), 8'($urandom), 8'($urandom));
        1: do_read("rnd_rd", 8'($urandom), int'($urandom_range(1, 3)));
        default: begin
          a = {7'($urandom), 1'b0};
          if (a[7:1] == 7'h1A) a = a ^ 8'h02;
          do_write("rnd_bad", a, 8'($urandom), 1, 8'($urandom), 8'h00, 8'h00);
        end
      endcase
    end

    chk("strobe_rules", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
